// File: rtl/pc_trace_monitor.sv
// Run controller and commit-trace recorder that sits beside the core.
// It sequences core reset, counts run cycles, detects halt or timeout, and keeps a circular PC/instruction trace.
module pc_trace_monitor #(
  parameter int unsigned PC_W        = 32,
  parameter int unsigned INSTR_W     = 32,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned MAX_CYCLES  = 1000,
  parameter int unsigned HALT_REPEAT = 4,
  parameter int unsigned RESET_HOLD  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     core_rst,
  input  logic                     commit_valid,
  input  logic [PC_W-1:0]          pc_in,
  input  logic [INSTR_W-1:0]       instr_in,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output logic [PC_W-1:0]          rd_pc,
  output logic [INSTR_W-1:0]       rd_instr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     running,
  output logic                     halted,
  output logic                     timeout,
  output logic [31:0]              cycle_count
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam int unsigned REP_W  = $clog2(HALT_REPEAT + 1);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(HALT_REPEAT);
  localparam logic [31:0]       CYC_LAST  = 32'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);

  typedef enum logic [1:0] {S_HOLD, S_RUN, S_HALT, S_TMO} state_e;

  state_e              state_q, state_d;
  logic                rel_q;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [31:0]         cycle_q, cycle_d;
  logic [PC_W-1:0]     last_pc_q, last_pc_d;
  logic                last_valid_q, last_valid_d;
  logic [REP_W-1:0]    rep_q, rep_d, rep_next;
  logic                halt_hit;

  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                overflow_q, overflow_d;
  logic                rd_valid_q, rd_valid_d;
  logic [PC_W-1:0]     rd_pc_q, rd_pc_d;
  logic [INSTR_W-1:0]  rd_instr_q, rd_instr_d;

  logic [PC_W-1:0]     pc_mem    [DEPTH];
  logic [INSTR_W-1:0]  instr_mem [DEPTH];

  logic wr_en, rd_fire, full;

  assign wr_en   = commit_valid && (state_q == S_RUN);
  assign rd_fire = rd_en && (count_q != '0);
  assign full    = (count_q == CNT_FULL);

  // NOTE: every variable gets its default first so no path through the block leaves it unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    cycle_d      = cycle_q;
    last_pc_d    = last_pc_q;
    last_valid_d = last_valid_q;
    rep_d        = rep_q;
    rep_next     = REP_W'(1);
    halt_hit     = 1'b0;

    if (wr_en) begin
      if (last_valid_q && (pc_in == last_pc_q)) rep_next = rep_q + REP_W'(1);
      rep_d        = rep_next;
      last_pc_d    = pc_in;
      last_valid_d = 1'b1;
      halt_hit     = (rep_next == REP_LAST);
    end

    unique case (state_q)
      // The first edge after release only registers it; the hold count starts on the next one.
      S_HOLD: begin
        if (rel_q) begin
          if (hold_cnt_q == HOLD_LAST) state_d = S_RUN;
          else                         hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      S_RUN: begin
        if (cycle_q != '1) cycle_d = cycle_q + 32'd1;
        if (halt_hit)                 state_d = S_HALT;
        else if (cycle_q == CYC_LAST) state_d = S_TMO;
      end
      default: ;
    endcase
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    rd_valid_d = rd_fire;
    rd_pc_d    = rd_pc_q;
    rd_instr_d = rd_instr_q;

    if (rd_fire) begin
      rd_pc_d    = pc_mem[rd_ptr_q];
      rd_instr_d = instr_mem[rd_ptr_q];
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
    end

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      // A simultaneous pop frees the slot, so only a lone write into a full buffer drops the oldest entry.
      if (!rd_fire) begin
        if (full) begin
          rd_ptr_d   = rd_ptr_q + PTR_W'(1);
          overflow_d = 1'b1;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
    end else if (rd_fire) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_HOLD;
      rel_q        <= 1'b0;
      hold_cnt_q   <= '0;
      cycle_q      <= '0;
      last_pc_q    <= '0;
      last_valid_q <= 1'b0;
      rep_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_pc_q      <= '0;
      rd_instr_q   <= '0;
    end else begin
      state_q      <= state_d;
      rel_q        <= 1'b1;
      hold_cnt_q   <= hold_cnt_d;
      cycle_q      <= cycle_d;
      last_pc_q    <= last_pc_d;
      last_valid_q <= last_valid_d;
      rep_q        <= rep_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      rd_valid_q   <= rd_valid_d;
      rd_pc_q      <= rd_pc_d;
      rd_instr_q   <= rd_instr_d;
    end
  end

  // NOTE: trace storage is deliberately not reset; count_q=0 hides stale entries and the array can map to RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem[wr_ptr_q]    <= pc_in;
      instr_mem[wr_ptr_q] <= instr_in;
    end
  end

  assign core_rst    = (state_q == S_HOLD);
  assign running     = (state_q == S_RUN);
  assign halted      = (state_q == S_HALT);
  assign timeout     = (state_q == S_TMO);
  assign cycle_count = cycle_q;
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign rd_valid    = rd_valid_q;
  assign rd_pc       = rd_pc_q;
  assign rd_instr    = rd_instr_q;

endmodule
